// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg: types and constants shared by the serial feeder and the detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam bit IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/serial_bit_feeder_if.sv
// ============================================================================
// serial_bit_feeder_if: word load handshake plus serial bit/framing outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             flush;
  logic             sequence_out;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_done;

  modport master (
    output load_data, load_valid, flush,
    input  load_ready, sequence_out, bit_valid, frame_start, frame_done
  );

  modport slave (
    input  load_data, load_valid, flush,
    output load_ready, sequence_out, bit_valid, frame_start, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/serial_bit_feeder_counter.sv
// ============================================================================
// bit_index_counter: modulo-WIDTH bit index with clear, enable and last flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_index_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          clear,
  input  wire logic          enable,
  output logic [CW-1:0]      count,
  output logic               last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST_IDX) ? '0 : r_count + CW'(1);
    end
  end

  assign count = r_count;
  assign last  = (r_count == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/serial_bit_feeder.sv
// ============================================================================
// serial_bit_feeder: parallel-to-serial stage, one bit per clock, no gaps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input wire logic           clock,
  input wire logic           reset,
  serial_bit_feeder_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_seq;
  logic             r_valid;
  logic             r_start;
  logic             r_done;

  logic [CW-1:0]    w_count;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_shift_bit;
  logic [WIDTH-1:0] w_shift_rest;

  // r_shift holds the bits still to be sent after the one on sequence_out.
  if (MSB_FIRST) begin : g_msb_first
    assign w_load_bit   = bus.load_data[WIDTH-1];
    assign w_load_rest  = {bus.load_data[WIDTH-2:0], IDLE_LEVEL};
    assign w_shift_bit  = r_shift[WIDTH-1];
    assign w_shift_rest = {r_shift[WIDTH-2:0], IDLE_LEVEL};
  end else begin : g_lsb_first
    assign w_load_bit   = bus.load_data[0];
    assign w_load_rest  = {IDLE_LEVEL, bus.load_data[WIDTH-1:1]};
    assign w_shift_bit  = r_shift[0];
    assign w_shift_rest = {IDLE_LEVEL, r_shift[WIDTH-1:1]};
  end

  assign w_ready  = !reset && !bus.flush &&
                    ((r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_last));
  assign w_accept = bus.load_valid && w_ready;

  bit_index_counter #(
    .WIDTH (WIDTH)
  ) u_bit_index_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.flush || w_accept || w_last),
    .enable ((r_state == ST_SHIFT) && !w_last),
    .count  (w_count),
    .last   (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      r_state <= ST_IDLE;
      r_shift <= {WIDTH{IDLE_LEVEL}};
      r_seq   <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shift <= w_load_rest;
      r_seq   <= w_load_bit;
      r_valid <= 1'b1;
      r_start <= 1'b1;
      r_done  <= 1'b0;
    end else if ((r_state == ST_SHIFT) && !w_last) begin
      r_shift <= w_shift_rest;
      r_seq   <= w_shift_bit;
      r_valid <= 1'b1;
      r_start <= 1'b0;
      r_done  <= (w_count == PRE_LAST);
    end else begin
      r_state <= ST_IDLE;
      r_seq   <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end
  end

  assign bus.load_ready   = w_ready;
  assign bus.sequence_out = r_seq;
  assign bus.bit_valid    = r_valid;
  assign bus.frame_start  = r_start;
  assign bus.frame_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
// ============================================================================
// tb_serial_bit_feeder: MSB-first and LSB-first feeders against a bit-queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_bit_feeder;
  import seq_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  serial_bit_feeder_if #(.WIDTH(W)) bus_m ();
  serial_bit_feeder_if #(.WIDTH(W)) bus_l ();

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clock (clock),
    .reset (reset),
    .bus   (bus_m.slave)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clock (clock),
    .reset (reset),
    .bus   (bus_l.slave)
  );

  // Model: per-DUT queue of bits still to appear, plus the expected current beat.
  beat_t pend [2][$];
  logic  exp_seq [2];
  logic  exp_vld [2];
  logic  exp_sta [2];
  logic  exp_don [2];
  bit    cfg_msb [2] = '{1'b1, 1'b0};
  bit    cfg_idl [2] = '{1'b0, 1'b1};

  task automatic check(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, idx, $time, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r,
                      output logic accepted);
    logic exp_ready;
    @(negedge clock);
    reset            = r;
    bus_m.load_valid = v;  bus_l.load_valid = v;
    bus_m.load_data  = d;  bus_l.load_data  = d;
    bus_m.flush      = f;  bus_l.flush      = f;
    #1;
    exp_ready = !r && !f && (pend[0].size() == 0);
    check("load_ready", 0, bus_m.load_ready, exp_ready);
    check("load_ready", 1, bus_l.load_ready, !r && !f && (pend[1].size() == 0));
    accepted = v && exp_ready;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (r || f) pend[i].delete();
      else if (accepted) begin
        for (int k = 0; k < W; k++) begin
          beat_t bt;
          bt.b = cfg_msb[i] ? d[W-1-k] : d[k];
          bt.s = (k == 0);
          bt.d = (k == W - 1);
          pend[i].push_back(bt);
        end
      end
      if (pend[i].size() > 0) begin
        beat_t cur;
        cur = pend[i].pop_front();
        exp_seq[i] = cur.b; exp_vld[i] = 1'b1; exp_sta[i] = cur.s; exp_don[i] = cur.d;
      end else begin
        exp_seq[i] = cfg_idl[i]; exp_vld[i] = 1'b0; exp_sta[i] = 1'b0; exp_don[i] = 1'b0;
      end
    end
    #1;
    check("sequence_out", 0, bus_m.sequence_out, exp_seq[0]);
    check("bit_valid",    0, bus_m.bit_valid,    exp_vld[0]);
    check("frame_start",  0, bus_m.frame_start,  exp_sta[0]);
    check("frame_done",   0, bus_m.frame_done,   exp_don[0]);
    check("sequence_out", 1, bus_l.sequence_out, exp_seq[1]);
    check("bit_valid",    1, bus_l.bit_valid,    exp_vld[1]);
    check("frame_start",  1, bus_l.frame_start,  exp_sta[1]);
    check("frame_done",   1, bus_l.frame_done,   exp_don[1]);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, a);
  endtask

  task automatic send(input logic [W-1:0] d);
    logic a;
    a = 1'b0;
    for (int n = 0; n < 40 && !a; n++) step(1'b1, d, 1'b0, 1'b0, a);
    check("send_accept_within_budget", 0, a, 1'b1);
  endtask

  initial begin
    logic a;
    bus_m.load_valid = 1'b0; bus_l.load_valid = 1'b0;
    bus_m.load_data  = '0;   bus_l.load_data  = '0;
    bus_m.flush      = 1'b0; bus_l.flush      = 1'b0;

    step(1'b0, '0, 1'b0, 1'b1, a);
    step(1'b1, 8'hAA, 1'b0, 1'b1, a);

    // Single word, then back-to-back words with valid held through the shift.
    send(8'hB5);
    idle(10);
    send(8'hB5);
    send(8'h0F);
    idle(10);
    send(8'h01);
    idle(10);

    // Flush at bit index 4, then a reload one cycle later.
    send(8'hFF);
    idle(4);
    step(1'b1, 8'h3C, 1'b1, 1'b0, a);
    step(1'b1, 8'h3C, 1'b0, 1'b0, a);
    idle(10);

    // Reset at bit index 2.
    send(8'b1011_0000);
    idle(2);
    step(1'b1, 8'h5A, 1'b0, 1'b1, a);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 20) == 0, ($urandom % 40) == 0, a);
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
